// File: rtl/fifo_wptr_full.sv
// Write-domain side of an async FIFO: gates producer writes, drives the memory write port,
// exports a Gray write pointer and derives full / almost-full / level from the synced read pointer.
module fifo_wptr_full #(
  parameter int ADDRSIZE     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                wclk_i,
  input  logic                wrst_n_i,
  input  logic                winc_i,
  input  logic [ADDRSIZE:0]   rptr_gray_i,
  output logic                wen_o,
  output logic [ADDRSIZE-1:0] wr_addr_o,
  output logic                fifo_full_o,
  output logic                fifo_afull_o,
  output logic [ADDRSIZE:0]   wptr_gray_o,
  output logic [ADDRSIZE:0]   wr_level_o,
  output logic                overflow_o
);

  localparam int DEPTH = 1 << ADDRSIZE;
  // Level threshold form of "free slots <= AFULL_MARGIN"; level never exceeds DEPTH in use.
  localparam logic [ADDRSIZE:0] AFULL_LEVEL = (ADDRSIZE+1)'(DEPTH - AFULL_MARGIN);

  logic [ADDRSIZE:0] wbin_q,  wbin_d;
  logic [ADDRSIZE:0] wgray_q, wgray_d;
  logic [ADDRSIZE:0] level_q, level_d;
  logic              full_q,  full_d;
  logic              afull_q, afull_d;
  logic              ovf_q,   ovf_d;
  logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
  logic [ADDRSIZE:0] sync_d [SYNC_STAGES];
  logic [ADDRSIZE:0] rgray_s;
  logic [ADDRSIZE:0] rbin_s;
  logic              wen;

  always_comb begin
    wen     = winc_i & ~full_q;
    wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, wen};
    wgray_d = wbin_d ^ (wbin_d >> 1);

    sync_d[0] = rptr_gray_i;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    rgray_s = sync_q[SYNC_STAGES-1];

    rbin_s           = '0;
    rbin_s[ADDRSIZE] = rgray_s[ADDRSIZE];
    for (int unsigned i = ADDRSIZE; i > 0; i--) begin
      rbin_s[i-1] = rbin_s[i] ^ rgray_s[i-1];
    end

    // Full when next write pointer is exactly one lap ahead of the synced read pointer.
    full_d  = (wgray_d == {~rgray_s[ADDRSIZE:ADDRSIZE-1], rgray_s[ADDRSIZE-2:0]});
    level_d = wbin_d - rbin_s;
    afull_d = (level_d >= AFULL_LEVEL);
    ovf_d   = ovf_q | (winc_i & full_q);
  end

  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign wen_o        = wen;
  assign wr_addr_o    = wbin_q[ADDRSIZE-1:0];
  assign fifo_full_o  = full_q;
  assign fifo_afull_o = afull_q;
  assign wptr_gray_o  = wgray_q;
  assign wr_level_o   = level_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed and random bench for fifo_wptr_full; a count-based occupancy model predicts every output.
module tb_fifo_wptr_full;

  logic       wclk_i = 1'b0;
  logic       wrst_n_i;
  logic       winc_i;
  logic [4:0] rptr_gray_i;
  logic       wen_o;
  logic [3:0] wr_addr_o;
  logic       fifo_full_o;
  logic       fifo_afull_o;
  logic [4:0] wptr_gray_o;
  logic [4:0] wr_level_o;
  logic       overflow_o;

  fifo_wptr_full #(.ADDRSIZE(4), .SYNC_STAGES(2), .AFULL_MARGIN(2)) dut (
    .wclk_i      (wclk_i),
    .wrst_n_i    (wrst_n_i),
    .winc_i      (winc_i),
    .rptr_gray_i (rptr_gray_i),
    .wen_o       (wen_o),
    .wr_addr_o   (wr_addr_o),
    .fifo_full_o (fifo_full_o),
    .fifo_afull_o(fifo_afull_o),
    .wptr_gray_o (wptr_gray_o),
    .wr_level_o  (wr_level_o),
    .overflow_o  (overflow_o)
  );

  always #5 wclk_i = ~wclk_i;

  int errors = 0;
  int checks = 0;

  // Reference state: counts of writes/reads (mod 32) and read values seen at each edge.
  int m_wcnt, m_level, rd_cnt;
  bit m_full, m_afull, m_ovf;
  int rdq[$];
  int whist[$];
  int acc_model, acc_dut;

  function automatic logic [4:0] gray(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive inputs, check wen before the edge, advance model, check after.
  task automatic cycle(input bit winc);
    bit ewen, old_full;
    int seen;
    winc_i      = winc;
    rptr_gray_i = gray(rd_cnt);
    #2;
    ewen = winc & ~m_full;
    chk("wen", wen_o, ewen);
    chk("wr_addr", wr_addr_o, m_wcnt & 15);
    if (wen_o === 1'b1) acc_dut++;
    @(posedge wclk_i);
    old_full = m_full;
    rdq.push_back(rd_cnt);
    if (rdq.size() > 3) void'(rdq.pop_front());
    seen = (rdq.size() == 3) ? rdq[0] : 0;
    if (ewen) begin
      m_wcnt = (m_wcnt + 1) & 31;
      acc_model++;
    end
    m_ovf   = m_ovf | (winc & old_full);
    m_level = (m_wcnt - seen) & 31;
    m_full  = (m_level == 16);
    m_afull = ((16 - m_level) <= 2);
    #1;
    chk("gray", wptr_gray_o, gray(m_wcnt));
    chk("level", wr_level_o, m_level);
    chk("full", fifo_full_o, m_full);
    chk("afull", fifo_afull_o, m_afull);
    chk("overflow", overflow_o, m_ovf);
  endtask

  // Called at posedge+1: assert reset between edges, check outputs cleared before next edge.
  task automatic do_reset();
    #1;
    wrst_n_i = 1'b0;
    #1;
    chk("rst_gray", wptr_gray_o, 0);
    chk("rst_addr", wr_addr_o, 0);
    chk("rst_level", wr_level_o, 0);
    chk("rst_flags", {fifo_full_o, fifo_afull_o, overflow_o}, 0);
    winc_i      = 1'b0;
    rd_cnt      = 0;
    rptr_gray_i = 5'd0;
    #1;
    chk("rst_wen", wen_o, 0);
    repeat (2) @(posedge wclk_i);
    #1;
    wrst_n_i = 1'b1;
    m_wcnt = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    rdq.delete();
    whist.delete();
  endtask

  initial begin
    logic [4:0] g0;
    bit         wrapped;
    wrst_n_i    = 1'b0;
    winc_i      = 1'b0;
    rptr_gray_i = 5'd0;
    acc_model   = 0;
    acc_dut     = 0;
    @(posedge wclk_i);
    #1;
    do_reset();

    // 1: fill from empty
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1);
      chk("t1_afull", fifo_afull_o, (i >= 13));
      chk("t1_full", fifo_full_o, (i == 15));
    end
    chk("t1_gray16", wptr_gray_o, 5'b11000);
    chk("t1_level16", wr_level_o, 16);
    chk("t1_addr_wrap", wr_addr_o, 0);

    // 2: writes while full are rejected and flag overflow
    for (int i = 0; i < 3; i++) cycle(1'b1);
    chk("t2_gray_hold", wptr_gray_o, 5'b11000);
    chk("t2_ovf", overflow_o, 1);
    cycle(1'b0);
    chk("t2_ovf_sticky", overflow_o, 1);

    // 3: one read frees a slot after the synchronizer latency
    rd_cnt = 1;
    cycle(1'b0); chk("t3_full_e1", fifo_full_o, 1);
    cycle(1'b0); chk("t3_full_e2", fifo_full_o, 1);
    cycle(1'b0); chk("t3_full_e3", fifo_full_o, 0);
    chk("t3_level15", wr_level_o, 15);
    chk("t3_afull", fifo_afull_o, 1);
    cycle(1'b1);
    chk("t3_refull", fifo_full_o, 1);

    // 4: streaming with reader lagging four cycles
    do_reset();
    wrapped = 0;
    for (int i = 0; i < 40; i++) begin
      whist.push_back(m_wcnt);
      if (whist.size() > 4) rd_cnt = whist.pop_front();
      g0 = wptr_gray_o;
      cycle(1'b1);
      chk("t4_onebit", $countones(g0 ^ wptr_gray_o), 1);
      chk("t4_notfull", fifo_full_o, 0);
      if (g0 == 5'b10000 && wptr_gray_o == 5'b00000) wrapped = 1;
    end
    chk("t4_wrap", wrapped, 1);

    // 5: async reset mid-stream, then first write goes to address 0
    do_reset();
    chk("t5_addr0", wr_addr_o, 0);
    cycle(1'b1);
    chk("t5_addr1", wr_addr_o, 1);

    // 6: random producer and reader
    do_reset();
    acc_model = 0;
    acc_dut   = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0 && ((m_wcnt - rd_cnt) & 31) != 0) rd_cnt = (rd_cnt + 1) & 31;
      cycle(1'($urandom_range(0, 3) != 0));
      chk("t6_nowrite_full", wen_o & fifo_full_o, 0);
      chk("t6_level_max", (wr_level_o <= 5'd16), 1);
      chk("t6_level_ge_occ", (int'(wr_level_o) >= ((m_wcnt - rd_cnt) & 31)), 1);
    end
    chk("t6_accepted", acc_dut, acc_model);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
